memory_access_arbiter: RTL and testbench



---
 rtl/memory_access_arbiter.sv | 124 ++++++++++++
 tb/tb_memory_access_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_arbiter.sv
// memory_access_arbiter
//   Shares one data-memory port between requester A (CPU datapath) and
//   requester B (I/O / secondary port). Round-robin arbitration, a fixed
//   ACCESS_CYCLES-long enable window per access, then a one-cycle ack.
//
// Ports
//   clock            : system clock, rising-edge state updates
//   reset            : asynchronous, active-high reset
//   req_a / req_b    : level requests, held until the matching ack
//   write_a/write_b  : access type (1 = write), sampled at grant
//   selector_address : address-mux select (0 = A, 1 = B)
//   memory_enable    : high for the whole access window
//   memory_write     : high only during a write access window
//   ack_a / ack_b    : one-cycle completion pulses
//   busy             : high in ACCESS and DONE
//
// All outputs are registered.
module memory_access_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned COUNT_WIDTH   = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic req_a,
    input  logic write_a,
    input  logic req_b,
    input  logic write_b,
    output logic selector_address,
    output logic memory_enable,
    output logic memory_write,
    output logic ack_a,
    output logic ack_b,
    output logic busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] LP_COUNT_INIT = COUNT_WIDTH'(ACCESS_CYCLES - 1);

    state_t                 r_state;
    logic                   r_last_grant;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_sel;
    logic                   r_enable;
    logic                   r_write;
    logic                   r_ack_a;
    logic                   r_ack_b;
    logic                   r_busy;

    logic w_grant_valid;
    logic w_grant_b;
    logic w_grant_write;

    // B wins when it is the only requester, or on a tie when A had the
    // last grant.
    assign w_grant_valid = req_a | req_b;
    assign w_grant_b     = req_b & (~req_a | ~r_last_grant);
    assign w_grant_write = w_grant_b ? write_b : write_a;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_count      <= '0;
            r_sel        <= 1'b0;
            r_enable     <= 1'b0;
            r_write      <= 1'b0;
            r_ack_a      <= 1'b0;
            r_ack_b      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_sel        <= w_grant_b;
                        r_last_grant <= w_grant_b;
                        r_write      <= w_grant_write;
                        r_count      <= LP_COUNT_INIT;
                        r_enable     <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_count == '0) begin
                        r_enable <= 1'b0;
                        r_write  <= 1'b0;
                        r_ack_a  <= ~r_sel;
                        r_ack_b  <= r_sel;
                        r_state  <= S_DONE;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                S_DONE: begin
                    r_ack_a <= 1'b0;
                    r_ack_b <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_enable <= 1'b0;
                    r_write  <= 1'b0;
                    r_ack_a  <= 1'b0;
                    r_ack_b  <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign selector_address = r_sel;
    assign memory_enable    = r_enable;
    assign memory_write     = r_write;
    assign ack_a            = r_ack_a;
    assign ack_b            = r_ack_b;
    assign busy             = r_busy;

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Testbench for memory_access_arbiter: two instances (ACCESS_CYCLES = 2 and
// ACCESS_CYCLES = 1) run side by side with independent requesters, checked
// every cycle against a phase-based reference model.
module tb_memory_access_arbiter;

    localparam int AC0 = 2;
    localparam int AC1 = 1;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] req_a, write_a, req_b, write_b;
    logic [1:0] sel, en, wr, ack_a, ack_b, busy;

    always #5 clock = ~clock;

    memory_access_arbiter #(.ACCESS_CYCLES(AC0), .COUNT_WIDTH(4)) u_dut0 (
        .clock(clock), .reset(reset),
        .req_a(req_a[0]), .write_a(write_a[0]),
        .req_b(req_b[0]), .write_b(write_b[0]),
        .selector_address(sel[0]), .memory_enable(en[0]),
        .memory_write(wr[0]), .ack_a(ack_a[0]), .ack_b(ack_b[0]),
        .busy(busy[0])
    );

    memory_access_arbiter #(.ACCESS_CYCLES(AC1), .COUNT_WIDTH(4)) u_dut1 (
        .clock(clock), .reset(reset),
        .req_a(req_a[1]), .write_a(write_a[1]),
        .req_b(req_b[1]), .write_b(write_b[1]),
        .selector_address(sel[1]), .memory_enable(en[1]),
        .memory_write(wr[1]), .ack_a(ack_a[1]), .ack_b(ack_b[1]),
        .busy(busy[1])
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: m_k is the position inside the current access
    // (0 = idle, 1..AC = enable window, AC+1 = ack cycle).
    int   m_k[2];
    logic m_id[2];
    logic m_wr[2];
    logic m_last[2];
    logic m_sel[2];

    int   rate_a[2];
    int   rate_b[2];
    logic order_check = 1'b0;
    logic exp_grant[2];

    function automatic int ac(input int i);
        return (i == 0) ? AC0 : AC1;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_k[i]    = 0;
            m_id[i]   = 1'b0;
            m_wr[i]   = 1'b0;
            m_last[i] = 1'b1;
            m_sel[i]  = 1'b0;
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            logic e_en;
            e_en = (m_k[i] >= 1) && (m_k[i] <= ac(i));
            check($sformatf("i%0d memory_enable", i), en[i], e_en);
            check($sformatf("i%0d memory_write", i), wr[i], e_en & m_wr[i]);
            check($sformatf("i%0d ack_a", i), ack_a[i], (m_k[i] == ac(i) + 1) && !m_id[i]);
            check($sformatf("i%0d ack_b", i), ack_b[i], (m_k[i] == ac(i) + 1) && m_id[i]);
            check($sformatf("i%0d busy", i), busy[i], m_k[i] != 0);
            check($sformatf("i%0d selector", i), sel[i], m_sel[i]);
            check($sformatf("i%0d ack exclusive", i), ack_a[i] & ack_b[i], 1'b0);
            if (order_check && m_k[i] == 1) begin
                check($sformatf("i%0d grant order", i), sel[i], exp_grant[i]);
                exp_grant[i] = ~exp_grant[i];
            end
        end
    endtask

    // Requesters: drop req on the ack cycle, raise with a given probability
    // when idle, and scramble write after being granted.
    task automatic drive_reqs();
        for (int i = 0; i < 2; i++) begin
            if (m_k[i] == ac(i) + 1 && !m_id[i]) req_a[i] = 1'b0;
            else if (!req_a[i] && $urandom_range(0, 99) < rate_a[i]) begin
                req_a[i]   = 1'b1;
                write_a[i] = 1'($urandom);
            end else if (m_k[i] >= 1 && m_k[i] <= ac(i) && !m_id[i]) write_a[i] = 1'($urandom);

            if (m_k[i] == ac(i) + 1 && m_id[i]) req_b[i] = 1'b0;
            else if (!req_b[i] && $urandom_range(0, 99) < rate_b[i]) begin
                req_b[i]   = 1'b1;
                write_b[i] = 1'($urandom);
            end else if (m_k[i] >= 1 && m_k[i] <= ac(i) && m_id[i]) write_b[i] = 1'($urandom);
        end
    endtask

    task automatic model_advance();
        for (int i = 0; i < 2; i++) begin
            if (m_k[i] == 0) begin
                if (req_a[i] || req_b[i]) begin
                    logic gb;
                    gb        = req_b[i] && (!req_a[i] || m_last[i] == 1'b0);
                    m_id[i]   = gb;
                    m_wr[i]   = gb ? write_b[i] : write_a[i];
                    m_last[i] = gb;
                    m_sel[i]  = gb;
                    m_k[i]    = 1;
                end
            end else if (m_k[i] == ac(i) + 1) begin
                m_k[i] = 0;
            end else begin
                m_k[i] = m_k[i] + 1;
            end
        end
    endtask

    task automatic tick_begin();
        @(negedge clock);
        check_outputs();
        drive_reqs();
    endtask

    task automatic cycle(input int n);
        for (int c = 0; c < n; c++) begin
            tick_begin();
            model_advance();
        end
    endtask

    task automatic set_rates(input int ra, input int rb);
        for (int i = 0; i < 2; i++) begin
            rate_a[i] = ra;
            rate_b[i] = rb;
        end
    endtask

    initial begin
        logic found;
        reset   = 1'b1;
        req_a   = '0;
        req_b   = '0;
        write_a = '0;
        write_b = '0;
        set_rates(0, 0);
        model_reset();
        exp_grant[0] = 1'b0;
        exp_grant[1] = 1'b0;

        // Reset state
        repeat (2) begin
            @(negedge clock);
            check_outputs();
        end

        // A alone, read, right at reset release
        req_a   = 2'b11;
        write_a = 2'b00;
        reset   = 1'b0;
        model_advance();
        cycle(6);

        // B alone, write
        tick_begin();
        req_b   = 2'b11;
        write_b = 2'b11;
        model_advance();
        cycle(6);

        // B rises while A is in its access window
        tick_begin();
        req_a   = 2'b11;
        write_a = 2'b11;
        model_advance();
        cycle(2);
        tick_begin();
        req_b   = 2'b11;
        write_b = 2'b01;
        model_advance();
        cycle(10);

        // A drops req mid-access; the access must still complete and ack
        tick_begin();
        req_a   = 2'b11;
        write_a = 2'b10;
        model_advance();
        cycle(1);
        tick_begin();
        req_a = 2'b00;
        model_advance();
        cycle(6);

        // Reset during the 2nd access cycle of instance 0
        tick_begin();
        req_a = 2'b11;
        model_advance();
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            if (m_k[0] == 2) found = 1'b1;
            else cycle(1);
        end
        if (!found) begin
            n_checks++;
            n_err++;
            $error("FAIL reset-window timeout: observed=no access expected=access");
        end
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clock);
        check_outputs();

        // Both requesters continuously requesting from reset release
        req_a = 2'b11;
        req_b = 2'b11;
        set_rates(100, 100);
        reset = 1'b0;
        exp_grant[0] = 1'b0;
        exp_grant[1] = 1'b0;
        order_check  = 1'b1;
        model_advance();
        cycle(24);
        order_check = 1'b0;

        // Randomized traffic
        for (int r = 0; r < 10; r++) begin
            set_rates(int'($urandom_range(10, 90)), int'($urandom_range(10, 90)));
            cycle(40);
        end
        set_rates(0, 0);
        cycle(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
